// File: rtl/peg_l2_mac_tx_framer.sv
// Transmit MAC framer: prepends preamble/SFD, pads short frames, appends
// the CRC-32 FCS and enforces the inter-frame gap toward the RS.
module peg_l2_mac_tx_framer #(
  parameter int unsigned PKT_DATA_W  = 8,
  parameter int unsigned PKT_SIZE_W  = 16,
  parameter int unsigned MIN_FRM_LEN = 60,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_l2_mac_tx_en,
  input  logic                  config_l2_mac_tx_pad_en,
  input  logic                  config_l2_mac_tx_fcs_en,
  input  logic                  mac_pause_en,
  output logic [2:0]            l2_mac_tx_fsm_state,
  output logic [PKT_SIZE_W-1:0] l2_mac_tx_frm_cnt,
  output logic [PKT_SIZE_W-1:0] l2_mac_tx_drop_cnt,
  input  logic                  llc_tx_valid,
  input  logic                  llc_tx_sop,
  input  logic                  llc_tx_eop,
  input  logic [PKT_DATA_W-1:0] llc_tx_data,
  output logic                  llc_tx_ready,
  output logic                  rs_tx_valid,
  output logic                  rs_tx_sop,
  output logic                  rs_tx_eop,
  output logic [PKT_DATA_W-1:0] rs_tx_data,
  input  logic                  rs_tx_ready
);

  localparam int unsigned CRC_W     = 32;
  localparam int unsigned PRE_CNT_W = 3;
  localparam int unsigned FCS_IDX_W = 2;
  localparam int unsigned IFG_CNT_W = $clog2(IFG_BYTES + 1);

  localparam logic [CRC_W-1:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0]      CRC_POLY = 32'hEDB8_8320;
  localparam logic [PRE_CNT_W-1:0]  PRE_LAST = PRE_CNT_W'(6);
  localparam logic [FCS_IDX_W-1:0]  FCS_LAST = FCS_IDX_W'(3);
  localparam logic [PKT_SIZE_W-1:0] CNT_MAX  = '1;
  localparam logic [PKT_SIZE_W-1:0] MIN_LEN  = PKT_SIZE_W'(MIN_FRM_LEN);
  // The IDLE decision and PRE load cycles supply the remaining gap slots,
  // so the bus shows exactly IFG_BYTES idle cycles between eop and sop.
  localparam logic [IFG_CNT_W-1:0]  IFG_LAST = IFG_CNT_W'(IFG_BYTES - 2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } state_t;

  // Reflected CRC-32, one byte processed LSB first.
  function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] crc,
                                                 input logic [7:0] d);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t                state_q, state_nxt;
  logic [PRE_CNT_W-1:0]  pre_cnt_q, pre_cnt_nxt;
  logic [FCS_IDX_W-1:0]  fcs_idx_q, fcs_idx_nxt;
  logic [IFG_CNT_W-1:0]  ifg_cnt_q, ifg_cnt_nxt;
  logic [PKT_SIZE_W-1:0] byte_cnt_q, byte_cnt_nxt;
  logic [CRC_W-1:0]      crc_q, crc_nxt;
  logic                  pad_en_q, pad_en_nxt;
  logic                  fcs_en_q, fcs_en_nxt;
  logic [PKT_SIZE_W-1:0] frm_cnt_q, frm_cnt_nxt;
  logic [PKT_SIZE_W-1:0] drop_cnt_q, drop_cnt_nxt;
  logic                  valid_nxt, sop_nxt, eop_nxt;
  logic [PKT_DATA_W-1:0] data_nxt;
  logic                  ready_c;
  logic                  can_load_c;
  logic [PKT_SIZE_W-1:0] byte_inc_c;
  logic [7:0]            fcs_byte_c;

  assign can_load_c = !rs_tx_valid || rs_tx_ready;
  assign byte_inc_c = (byte_cnt_q == CNT_MAX) ? CNT_MAX : byte_cnt_q + PKT_SIZE_W'(1);
  assign fcs_byte_c = ~crc_q[{fcs_idx_q, 3'b000} +: 8];

  assign llc_tx_ready        = rst_n & ready_c;
  assign l2_mac_tx_fsm_state = state_q;
  assign l2_mac_tx_frm_cnt   = frm_cnt_q;
  assign l2_mac_tx_drop_cnt  = drop_cnt_q;

  // Next-state, datapath and output-stage load decisions.
  always_comb begin
    state_nxt    = state_q;
    pre_cnt_nxt  = pre_cnt_q;
    fcs_idx_nxt  = fcs_idx_q;
    ifg_cnt_nxt  = ifg_cnt_q;
    byte_cnt_nxt = byte_cnt_q;
    crc_nxt      = crc_q;
    pad_en_nxt   = pad_en_q;
    fcs_en_nxt   = fcs_en_q;
    frm_cnt_nxt  = frm_cnt_q;
    drop_cnt_nxt = drop_cnt_q;
    valid_nxt    = rs_tx_valid;
    sop_nxt      = rs_tx_sop;
    eop_nxt      = rs_tx_eop;
    data_nxt     = rs_tx_data;
    ready_c      = 1'b0;

    if (can_load_c) begin
      valid_nxt = 1'b0;
      sop_nxt   = 1'b0;
      eop_nxt   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (config_l2_mac_tx_en && !mac_pause_en && llc_tx_valid && llc_tx_sop) begin
          state_nxt = ST_PRE;
        end else if (llc_tx_valid && !llc_tx_sop) begin
          ready_c      = 1'b1;
          drop_cnt_nxt = drop_cnt_q + PKT_SIZE_W'(1);
        end
      end
      ST_PRE: begin
        if (can_load_c) begin
          valid_nxt = 1'b1;
          sop_nxt   = (pre_cnt_q == '0);
          data_nxt  = PKT_DATA_W'(8'h55);
          if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_nxt = '0;
            state_nxt   = ST_SFD;
          end else begin
            pre_cnt_nxt = pre_cnt_q + PRE_CNT_W'(1);
          end
        end
      end
      ST_SFD: begin
        if (can_load_c) begin
          valid_nxt    = 1'b1;
          data_nxt     = PKT_DATA_W'(8'hD5);
          crc_nxt      = CRC_INIT;
          byte_cnt_nxt = '0;
          pad_en_nxt   = config_l2_mac_tx_pad_en;
          fcs_en_nxt   = config_l2_mac_tx_fcs_en;
          state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        ready_c = can_load_c;
        if (can_load_c && llc_tx_valid) begin
          valid_nxt    = 1'b1;
          data_nxt     = llc_tx_data;
          crc_nxt      = crc32_byte(crc_q, 8'(llc_tx_data));
          byte_cnt_nxt = byte_inc_c;
          if (llc_tx_eop) begin
            if (pad_en_q && (byte_inc_c < MIN_LEN)) begin
              state_nxt = ST_PAD;
            end else if (fcs_en_q) begin
              state_nxt = ST_FCS;
            end else begin
              eop_nxt   = 1'b1;
              state_nxt = ST_IFG;
            end
          end
        end
      end
      ST_PAD: begin
        if (can_load_c) begin
          valid_nxt    = 1'b1;
          data_nxt     = '0;
          crc_nxt      = crc32_byte(crc_q, 8'h00);
          byte_cnt_nxt = byte_inc_c;
          if (byte_inc_c >= MIN_LEN) begin
            if (fcs_en_q) begin
              state_nxt = ST_FCS;
            end else begin
              eop_nxt   = 1'b1;
              state_nxt = ST_IFG;
            end
          end
        end
      end
      ST_FCS: begin
        if (can_load_c) begin
          valid_nxt = 1'b1;
          data_nxt  = PKT_DATA_W'(fcs_byte_c);
          if (fcs_idx_q == FCS_LAST) begin
            eop_nxt     = 1'b1;
            fcs_idx_nxt = '0;
            state_nxt   = ST_IFG;
          end else begin
            fcs_idx_nxt = fcs_idx_q + FCS_IDX_W'(1);
          end
        end
      end
      ST_IFG: begin
        if (rs_tx_ready) begin
          if (ifg_cnt_q == IFG_LAST) begin
            ifg_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end else begin
            ifg_cnt_nxt = ifg_cnt_q + IFG_CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if ((state_nxt == ST_IFG) && (state_q != ST_IFG)) begin
      frm_cnt_nxt = frm_cnt_q + PKT_SIZE_W'(1);
    end
  end

  // State, counters, CRC and registered RS output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      fcs_idx_q   <= '0;
      ifg_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      pad_en_q    <= 1'b0;
      fcs_en_q    <= 1'b0;
      frm_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      rs_tx_valid <= 1'b0;
      rs_tx_sop   <= 1'b0;
      rs_tx_eop   <= 1'b0;
      rs_tx_data  <= '0;
    end else begin
      state_q     <= state_nxt;
      pre_cnt_q   <= pre_cnt_nxt;
      fcs_idx_q   <= fcs_idx_nxt;
      ifg_cnt_q   <= ifg_cnt_nxt;
      byte_cnt_q  <= byte_cnt_nxt;
      crc_q       <= crc_nxt;
      pad_en_q    <= pad_en_nxt;
      fcs_en_q    <= fcs_en_nxt;
      frm_cnt_q   <= frm_cnt_nxt;
      drop_cnt_q  <= drop_cnt_nxt;
      rs_tx_valid <= valid_nxt;
      rs_tx_sop   <= sop_nxt;
      rs_tx_eop   <= eop_nxt;
      rs_tx_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
// Directed bench for peg_l2_mac_tx_framer with an expected-byte scoreboard.
module tb_peg_l2_mac_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        config_l2_mac_tx_en, config_l2_mac_tx_pad_en, config_l2_mac_tx_fcs_en;
  logic        mac_pause_en;
  logic [2:0]  l2_mac_tx_fsm_state;
  logic [15:0] l2_mac_tx_frm_cnt, l2_mac_tx_drop_cnt;
  logic        llc_tx_valid, llc_tx_sop, llc_tx_eop, llc_tx_ready;
  logic [7:0]  llc_tx_data;
  logic        rs_tx_valid, rs_tx_sop, rs_tx_eop, rs_tx_ready;
  logic [7:0]  rs_tx_data;

  int          checks = 0;
  int          failures = 0;
  int          xfers = 0;
  int          cyc = 0;
  int          last_eop_cyc = -1000;
  int          last_gap = -1;
  int          exp_frm = 0;
  bit          rand_ready = 1'b0;
  logic [9:0]  sb[$];

  always #5 clk = ~clk;

  peg_l2_mac_tx_framer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .config_l2_mac_tx_en     (config_l2_mac_tx_en),
    .config_l2_mac_tx_pad_en (config_l2_mac_tx_pad_en),
    .config_l2_mac_tx_fcs_en (config_l2_mac_tx_fcs_en),
    .mac_pause_en            (mac_pause_en),
    .l2_mac_tx_fsm_state     (l2_mac_tx_fsm_state),
    .l2_mac_tx_frm_cnt       (l2_mac_tx_frm_cnt),
    .l2_mac_tx_drop_cnt      (l2_mac_tx_drop_cnt),
    .llc_tx_valid            (llc_tx_valid),
    .llc_tx_sop              (llc_tx_sop),
    .llc_tx_eop              (llc_tx_eop),
    .llc_tx_data             (llc_tx_data),
    .llc_tx_ready            (llc_tx_ready),
    .rs_tx_valid             (rs_tx_valid),
    .rs_tx_sop               (rs_tx_sop),
    .rs_tx_eop               (rs_tx_eop),
    .rs_tx_data              (rs_tx_data),
    .rs_tx_ready             (rs_tx_ready)
  );

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic bq_t ramp(input int n, input logic [7:0] start);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(int'(start) + i));
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_hdr();
    for (int i = 0; i < 7; i++) sb.push_back({(i == 0), 1'b0, 8'h55});
    sb.push_back({2'b00, 8'hD5});
  endtask

  // Model of the framed byte stream for a payload under given pad/fcs settings.
  task automatic push_frame(input bq_t pl, input bit pad, input bit fcs);
    bq_t         f;
    logic [31:0] crc;
    logic [31:0] fv;
    f = pl;
    if (pad) while (f.size() < 60) f.push_back(8'h00);
    push_hdr();
    crc = 32'hFFFFFFFF;
    foreach (f[i]) begin
      crc = crc_upd(crc, f[i]);
      sb.push_back({1'b0, (i == f.size() - 1) && !fcs, f[i]});
    end
    if (fcs) begin
      fv = ~crc;
      for (int k = 0; k < 4; k++) sb.push_back({1'b0, (k == 3), fv[8*k +: 8]});
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    int   n;
    logic acc;
    llc_tx_valid = 1'b1;
    llc_tx_sop   = s;
    llc_tx_eop   = e;
    llc_tx_data  = d;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = llc_tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("llc_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input bq_t pl, input int pause_idx);
    foreach (pl[i]) begin
      if (i == pause_idx) mac_pause_en = 1'b1;
      drive_byte(pl[i], (i == 0), (i == pl.size() - 1));
    end
    llc_tx_valid = 1'b0;
    llc_tx_sop   = 1'b0;
    llc_tx_eop   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      done = (l2_mac_tx_fsm_state == 3'd0) && (sb.size() == 0);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Pops the scoreboard on every RS transfer and checks stall stability.
  task automatic monitor();
    logic [9:0] got, exp, prev;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      got = {rs_tx_sop, rs_tx_eop, rs_tx_data};
      if (prev_stall) begin
        checks++;
        assert (rs_tx_valid && got === prev) else begin
          failures++;
          $error("FAIL stall_stable got=%b/0x%0h exp=1/0x%0h", rs_tx_valid, got, prev);
        end
      end
      if (rs_tx_valid && rs_tx_ready) begin
        xfers++;
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_byte got=0x%0h exp=none", got);
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          checks++;
          assert (got === exp) else begin
            failures++;
            $error("FAIL rs_byte got=0x%0h exp=0x%0h", got, exp);
          end
        end
        if (rs_tx_sop) last_gap = cyc - last_eop_cyc - 1;
        if (rs_tx_eop) last_eop_cyc = cyc;
      end
      prev_stall = rs_tx_valid && !rs_tx_ready && rst_n;
      prev       = got;
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      rs_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    bq_t pl, pl2;
    int  x0;
    bit  saw_ready;
    rst_n = 1'b0;
    config_l2_mac_tx_en = 1'b1;
    config_l2_mac_tx_pad_en = 1'b0;
    config_l2_mac_tx_fcs_en = 1'b1;
    mac_pause_en = 1'b0;
    llc_tx_valid = 1'b0;
    llc_tx_sop = 1'b0;
    llc_tx_eop = 1'b0;
    llc_tx_data = '0;
    rs_tx_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset values, with a non-sop byte offered during reset
    repeat (3) @(posedge clk);
    #1;
    llc_tx_valid = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(l2_mac_tx_fsm_state), 32'd0);
    chk("rst_valid", 32'(rs_tx_valid), 32'd0);
    chk("rst_llc_ready", 32'(llc_tx_ready), 32'd0);
    chk("rst_frm", 32'(l2_mac_tx_frm_cnt), 32'd0);
    chk("rst_drop", 32'(l2_mac_tx_drop_cnt), 32'd0);
    llc_tx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "123456789" with known FCS bytes
    pl = ramp(9, 8'h31);
    push_hdr();
    foreach (pl[i]) sb.push_back({2'b00, pl[i]});
    sb.push_back({2'b00, 8'h26});
    sb.push_back({2'b00, 8'h39});
    sb.push_back({2'b00, 8'hF4});
    sb.push_back({2'b01, 8'hCB});
    send_frame(pl, -1);
    wait_idle("t1_done");
    exp_frm++;
    chk("t1_frm", 32'(l2_mac_tx_frm_cnt), 32'(exp_frm));

    // 14 bytes padded to 60 plus FCS
    config_l2_mac_tx_pad_en = 1'b1;
    pl = ramp(14, 8'h01);
    x0 = xfers;
    push_frame(pl, 1'b1, 1'b1);
    send_frame(pl, -1);
    wait_idle("t2_done");
    exp_frm++;
    chk("t2_len", 32'(xfers - x0), 32'd72);
    chk("t2_frm", 32'(l2_mac_tx_frm_cnt), 32'(exp_frm));

    // Padding without FCS: eop on the last pad byte
    config_l2_mac_tx_fcs_en = 1'b0;
    pl = ramp(3, 8'hE0);
    x0 = xfers;
    push_frame(pl, 1'b1, 1'b0);
    send_frame(pl, -1);
    wait_idle("t3_done");
    exp_frm++;
    chk("t3_len", 32'(xfers - x0), 32'd68);

    // Neither pad nor FCS: eop on the last data byte
    config_l2_mac_tx_pad_en = 1'b0;
    pl = ramp(5, 8'hF0);
    x0 = xfers;
    push_frame(pl, 1'b0, 1'b0);
    send_frame(pl, -1);
    wait_idle("t4_done");
    exp_frm++;
    chk("t4_len", 32'(xfers - x0), 32'd13);

    // Back-to-back frames: inter-frame gap
    config_l2_mac_tx_fcs_en = 1'b1;
    pl  = ramp(6, 8'h10);
    pl2 = ramp(6, 8'h20);
    push_frame(pl, 1'b0, 1'b1);
    push_frame(pl2, 1'b0, 1'b1);
    send_frame(pl, -1);
    send_frame(pl2, -1);
    wait_idle("t5_done");
    exp_frm += 2;
    chk("t5_gap", 32'(last_gap), 32'd12);
    chk("t5_frm", 32'(l2_mac_tx_frm_cnt), 32'(exp_frm));

    // Pause held before sop: nothing starts
    config_l2_mac_tx_pad_en = 1'b1;
    pl = ramp(10, 8'h60);
    mac_pause_en = 1'b1;
    llc_tx_valid = 1'b1;
    llc_tx_sop   = 1'b1;
    llc_tx_data  = pl[0];
    x0 = xfers;
    saw_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_ready = saw_ready | llc_tx_ready;
    end
    chk("pause_ready", 32'(saw_ready), 32'd0);
    chk("pause_xfers", 32'(xfers - x0), 32'd0);
    chk("pause_state", 32'(l2_mac_tx_fsm_state), 32'd0);
    @(posedge clk);
    #1;
    mac_pause_en = 1'b0;
    push_frame(pl, 1'b1, 1'b1);
    send_frame(pl, -1);
    wait_idle("t6_done");
    exp_frm++;

    // Pause raised mid-frame: frame completes intact
    pl = ramp(20, 8'h40);
    push_frame(pl, 1'b1, 1'b1);
    send_frame(pl, 5);
    wait_idle("t7_done");
    exp_frm++;
    chk("t7_frm", 32'(l2_mac_tx_frm_cnt), 32'(exp_frm));
    mac_pause_en = 1'b0;

    // 64-byte frame under random RS backpressure
    rand_ready = 1'b1;
    pl = ramp(64, 8'h80);
    x0 = xfers;
    push_frame(pl, 1'b1, 1'b1);
    send_frame(pl, -1);
    wait_idle("t8_done");
    rand_ready = 1'b0;
    exp_frm++;
    chk("t8_len", 32'(xfers - x0), 32'd76);
    chk("t8_frm", 32'(l2_mac_tx_frm_cnt), 32'(exp_frm));
    @(posedge clk);
    #1;

    // Orphan bytes in IDLE are dropped
    x0 = xfers;
    for (int k = 0; k < 3; k++) drive_byte(8'(8'hA0 + k), 1'b0, 1'b0);
    llc_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_cnt", 32'(l2_mac_tx_drop_cnt), 32'd3);
    chk("drop_xfers", 32'(xfers - x0), 32'd0);
    #1;

    // Reset while in DATA
    config_l2_mac_tx_pad_en = 1'b0;
    pl = ramp(5, 8'hC0);
    push_hdr();
    foreach (pl[i]) sb.push_back({2'b00, pl[i]});
    foreach (pl[i]) drive_byte(pl[i], (i == 0), 1'b0);
    llc_tx_valid = 1'b0;
    llc_tx_sop   = 1'b0;
    repeat (2) @(negedge clk);
    chk("prerst_state", 32'(l2_mac_tx_fsm_state), 32'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_state", 32'(l2_mac_tx_fsm_state), 32'd0);
    chk("midrst_valid", 32'(rs_tx_valid), 32'd0);
    chk("midrst_frm", 32'(l2_mac_tx_frm_cnt), 32'd0);
    chk("midrst_llc_ready", 32'(llc_tx_ready), 32'd0);
    chk("midrst_sb_left", 32'(sb.size()), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peg_l2_mac_tx_framer.md
Name: peg_l2_mac_tx_framer

Overview:
- Transmit-side MAC framer; counterpart of the L2 MAC RX parser path.
- Accepts frames (DA..payload) from the LLC packet interface and emits them toward the RS on a packet interface.
- Prepends preamble/SFD, pads short frames to 60 bytes, appends the CRC-32 FCS and enforces the inter-frame gap.
- Holds off new frames while mac_pause_en (from MAC RX pause counter) is high.

Parameters:
PKT_DATA_W, 8, byte lane width; only 8 is supported.
PKT_SIZE_W, 16, width of the frame byte counter and status counters.
MIN_FRM_LEN, 60, minimum frame length before FCS, in bytes.
IFG_BYTES, 12, inter-frame gap in byte slots.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
config_l2_mac_tx_en  in  1  enables frame start
config_l2_mac_tx_pad_en  in  1  enables padding to MIN_FRM_LEN
config_l2_mac_tx_fcs_en  in  1  enables FCS append
mac_pause_en  in  1  pause request from MAC RX
l2_mac_tx_fsm_state  out  3  current FSM state encoding
l2_mac_tx_frm_cnt  out  PKT_SIZE_W  frames sent, wraps
l2_mac_tx_drop_cnt  out  PKT_SIZE_W  orphan bytes dropped, wraps
llc_tx_valid / llc_tx_sop / llc_tx_eop  in  1 each  LLC input qualifiers
llc_tx_data  in  PKT_DATA_W  LLC byte
llc_tx_ready  out  1  LLC backpressure
rs_tx_valid / rs_tx_sop / rs_tx_eop  out  1 each  RS output qualifiers
rs_tx_data  out  PKT_DATA_W  RS byte
rs_tx_ready  in  1  RS backpressure

Behaviour:
- Transfers: input on llc_tx_valid&&llc_tx_ready; output on rs_tx_valid&&rs_tx_ready.
- Output stage is registered. It may load when !rs_tx_valid || rs_tx_ready. Latency from an LLC byte to the RS is 1 cycle.
- Reset: FSM=IDLE(0), all rs_tx_* = 0, llc_tx_ready = 0, counters = 0, CRC = 32'hFFFFFFFF, byte/IFG counters = 0.
- State encoding: IDLE=0, PRE=1, SFD=2, DATA=3, PAD=4, FCS=5, IFG=6.
- IDLE:
  - If config_l2_mac_tx_en && !mac_pause_en && llc_tx_valid && llc_tx_sop, go to PRE without consuming.
  - If llc_tx_valid && !llc_tx_sop, set llc_tx_ready=1, drop the byte and increment drop_cnt.
  - Otherwise llc_tx_ready=0.
- PRE: emit 7 bytes of 0x55; the first carries rs_tx_sop=1. Then go to SFD.
- SFD: emit 0xD5. Reset the CRC to FFFFFFFF and the byte counter to 0. Go to DATA.
- DATA:
  - llc_tx_ready = output stage can load.
  - Each accepted byte is emitted, CRC-updated, and increments the saturating byte counter.
  - llc_tx_valid low inserts bubbles (no output).
  - llc_tx_sop mid-frame is ignored; the byte is treated as data.
  - On an accepted eop byte:
    - next = PAD if pad_en && count+1 < MIN_FRM_LEN;
    - else next = FCS if fcs_en;
    - else IFG, and this byte carries rs_tx_eop.
- PAD: emit 0x00 and CRC-update until count == MIN_FRM_LEN. Then go to FCS (or IFG, with eop on the last pad byte, if !fcs_en).
- FCS:
  - CRC is CRC-32 (poly 0x04C11DB7, reflected, LSB-first per byte), init FFFFFFFF, covering DA through pad.
  - Emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]; the last byte carries rs_tx_eop.
  - Then go to IFG.
- IFG:
  - rs_tx_valid=0.
  - Count IFG_BYTES cycles in which rs_tx_ready=1, then go to IDLE.
  - frm_cnt increments on entry to IFG.
- Pause and enable changes:
  - mac_pause_en and config_l2_mac_tx_en are sampled only in IDLE. Asserting either mid-frame has no effect until the frame ends.
- Backpressure: rs_tx_ready low freezes all counters and the FSM except in IDLE. Output data stays stable while valid && !ready.
- Config bits pad_en and fcs_en are sampled at the SFD→DATA transition and held for the frame.
- Reset mid-frame: everything returns to reset values on the next edge; no partial frame completion.

Test Plan:
- 9-byte frame "123456789" (0x31..0x39), pad_en=0, fcs_en=1 → RS sees 55×7, D5, 31..39, 26 39 F4 CB; sop on first 55, eop on CB; frm_cnt=1.
- 14-byte frame, pad_en=1, fcs_en=1 → 8+14+46 zero pad+4 = 72 bytes; FCS matches a golden CRC over 60 bytes.
- Two back-to-back frames, rs_tx_ready=1 → exactly 12 idle cycles between eop and the next sop.
- mac_pause_en=1 before sop → no output and llc_tx_ready=0 until pause drops; pause raised mid-frame → the frame completes intact.
- rs_tx_ready toggled randomly at 50% during a 64-byte frame → byte stream identical to the unstalled run; data stable while stalled.
- 3 non-sop bytes in IDLE → drop_cnt=3, no RS output; rst_n low in DATA → next cycle state=0, rs_tx_valid=0.
